// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the 16-bit-bus UART transmitter.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    localparam int unsigned DefaultBaudDiv = 2604;

    localparam logic [2:0] AddrData   = 3'd0;
    localparam logic [2:0] AddrStatus = 3'd2;
    localparam logic [2:0] AddrCtrl   = 3'd4;

    localparam int unsigned StatBusyBit  = 0;
    localparam int unsigned StatFullBit  = 1;
    localparam int unsigned StatEmptyBit = 2;
    localparam int unsigned StatCountLsb = 3;
    localparam int unsigned StatOvfBit   = 6;

    localparam int unsigned CtrlIrqEnBit = 0;
    localparam int unsigned CtrlParEnBit = 1;

    // STATUS only has a 3-bit count field.
    function automatic logic [2:0] sat_count3(input int unsigned cnt);
        logic [2:0] res;
        res = (cnt > 32'd7) ? 3'd7 : cnt[2:0];
        return res;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide transmit FIFO with simultaneous push/pop; pushes while full are dropped.
module uart_tx_fifo #(
    parameter int unsigned Depth = 4,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic [7:0]      data_i,
    input  logic            pop_i,
    output logic [7:0]      data_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    logic [7:0]      mem_q [Depth];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/uart_tx16.sv
// UART transmitter on a 16-bit IO bus: DATA/STATUS/CTRL registers, byte FIFO,
// optional even parity and a level interrupt when the transmitter drains.
module uart_tx16 import uart_tx_pkg::*; #(
    parameter int unsigned BAUD_DIV   = DefaultBaudDiv,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        uartctrl,
    input  logic        iowrite,
    input  logic        ioread,
    input  logic [2:0]  address,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        txd,
    output logic        tx_irq
);

    localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BaudW = $clog2(BAUD_DIV);
    localparam logic [BaudW-1:0] BaudMax = BaudW'(BAUD_DIV - 1);

    tx_state_e        state_q;
    logic [BaudW-1:0] baud_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             parity_q, par_en_q;
    logic             txd_q, irq_q;
    logic [1:0]       ctrl_q;
    logic             ovf_q;

    logic            wr_data, wr_ctrl, rd_status, bit_end;
    logic            fifo_pop, fifo_full, fifo_empty;
    logic [7:0]      fifo_rdata;
    logic [CntW-1:0] fifo_count;
    logic [15:0]     status;
    logic            unused_wdata;

    assign wr_data   = uartctrl & iowrite & (address == AddrData);
    assign wr_ctrl   = uartctrl & iowrite & (address == AddrCtrl);
    assign rd_status = uartctrl & ioread & (address == AddrStatus);
    assign bit_end   = (baud_q == '0);
    assign unused_wdata = ^wdata[15:8];

    // Pop from idle, or back-to-back at the last cycle of a stop bit.
    assign fifo_pop = ~fifo_empty &
                      ((state_q == StIdle) | ((state_q == StStop) & bit_end));

    uart_tx_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (wr_data),
        .data_i  (wdata[7:0]),
        .pop_i   (fifo_pop),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctrl_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl_q <= wdata[1:0];
            if (wr_data & fifo_full) ovf_q <= 1'b1;
            else if (rd_status)      ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            par_en_q <= 1'b0;
            txd_q    <= 1'b1;
            irq_q    <= 1'b0;
        end else begin
            irq_q <= ctrl_q[CtrlIrqEnBit] & fifo_empty & (state_q == StIdle);
            if (state_q != StIdle) baud_q <= bit_end ? BaudMax : baud_q - 1'b1;
            if (bit_end) begin
                unique case (state_q)
                    StIdle: txd_q <= 1'b1;
                    StStart: begin
                        state_q <= StData;
                        bit_q   <= '0;
                        txd_q   <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                    end
                    StData: begin
                        if (bit_q == 3'd7) begin
                            if (par_en_q) begin
                                state_q <= StParity;
                                txd_q   <= parity_q;
                            end else begin
                                state_q <= StStop;
                                txd_q   <= 1'b1;
                            end
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            txd_q   <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                        end
                    end
                    StParity: begin
                        state_q <= StStop;
                        txd_q   <= 1'b1;
                    end
                    StStop: begin
                        state_q <= StIdle;
                        txd_q   <= 1'b1;
                        baud_q  <= '0;
                    end
                    default: state_q <= StIdle;
                endcase
            end
            // A pop overrides the idle/stop transitions above with a new frame.
            if (fifo_pop) begin
                state_q  <= StStart;
                shift_q  <= fifo_rdata;
                parity_q <= ^fifo_rdata;
                par_en_q <= ctrl_q[CtrlParEnBit];
                txd_q    <= 1'b0;
                baud_q   <= BaudMax;
            end
        end
    end

    always_comb begin
        status = '0;
        status[StatBusyBit]         = (state_q != StIdle);
        status[StatFullBit]         = fifo_full;
        status[StatEmptyBit]        = fifo_empty;
        status[StatCountLsb +: 3]   = sat_count3(32'(fifo_count));
        status[StatOvfBit]          = ovf_q;
    end

    always_comb begin
        rdata = '0;
        if (uartctrl & ioread) begin
            case (address)
                AddrStatus: rdata = status;
                AddrCtrl:   rdata = {14'b0, ctrl_q};
                default:    rdata = '0;
            endcase
        end
    end

    assign txd    = txd_q;
    assign tx_irq = irq_q;

endmodule

// File: tb/tb_uart_tx16.sv
// Directed bench for uart_tx16 with BAUD_DIV=4: register access, framing, FIFO overflow,
// reset abort and interrupt timing, all against hand-computed values.
module tb_uart_tx16;

    localparam int unsigned BaudDiv = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        uartctrl, iowrite, ioread;
    logic [2:0]  address;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        txd, tx_irq;

    int n_vec = 0;
    int n_err = 0;

    uart_tx16 #(
        .BAUD_DIV   (BaudDiv),
        .FIFO_DEPTH (4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .uartctrl (uartctrl),
        .iowrite  (iowrite),
        .ioread   (ioread),
        .address  (address),
        .wdata    (wdata),
        .rdata    (rdata),
        .txd      (txd),
        .tx_irq   (tx_irq)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] status_word(input bit busy, input bit full, input bit empty,
                                                input int cnt, input bit ovf);
        logic [15:0] w;
        w      = '0;
        w[0]   = busy;
        w[1]   = full;
        w[2]   = empty;
        w[5:3] = 3'(cnt);
        w[6]   = ovf;
        return w;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
        uartctrl = 1'b1;
        iowrite  = 1'b1;
        address  = a;
        wdata    = d;
        @(posedge clock);
        #1;
        uartctrl = 1'b0;
        iowrite  = 1'b0;
    endtask

    task automatic cpu_read_check(input logic [2:0] a, input logic [15:0] exp, input string tag);
        uartctrl = 1'b1;
        ioread   = 1'b1;
        address  = a;
        #1;
        check_eq(tag, rdata, exp);
        @(posedge clock);
        #1;
        uartctrl = 1'b0;
        ioread   = 1'b0;
    endtask

    // Entered on the first cycle of the start bit; checks txd and tx_irq=0 every cycle.
    task automatic check_frame(input logic [7:0] b, input bit par);
        logic [10:0] bits;
        int          n;
        bits = {1'b1, ^b, b, 1'b0};
        n    = par ? 11 : 10;
        if (!par) bits[9] = 1'b1;
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < int'(BaudDiv); c++) begin
                check_eq($sformatf("frame %h bit %0d cyc %0d", b, i, c),
                         {14'b0, txd, tx_irq}, {14'b0, bits[i], 1'b0});
                idle(1);
            end
        end
    endtask

    initial begin
        int lows;
        reset    = 1'b1;
        uartctrl = 1'b0;
        iowrite  = 1'b0;
        ioread   = 1'b0;
        address  = '0;
        wdata    = '0;
        idle(2);

        // Reset state, including a combinational read while reset is held.
        check_eq("reset txd", {15'b0, txd}, 16'h0001);
        check_eq("reset irq", {15'b0, tx_irq}, 16'h0000);
        cpu_read_check(3'd2, 16'h0004, "status in reset");
        reset = 1'b0;
        idle(1);
        cpu_read_check(3'd4, 16'h0000, "ctrl after reset");

        // 0x55, no parity: 40-cycle frame, idle afterwards.
        cpu_write(3'd0, 16'h0055);
        idle(1);
        check_frame(8'h55, 1'b0);
        cpu_read_check(3'd2, 16'h0004, "status after 0x55");

        // 0x07 with even parity: parity bit 1, 44-cycle frame.
        cpu_write(3'd4, 16'h0002);
        cpu_read_check(3'd4, 16'h0002, "ctrl par_en");
        cpu_write(3'd0, 16'h0007);
        idle(1);
        check_frame(8'h07, 1'b1);
        cpu_read_check(3'd2, 16'h0004, "status after 0x07");
        cpu_write(3'd4, 16'h0000);

        // Six back-to-back writes: one pops immediately, four fill the FIFO, the sixth drops.
        fork
            begin
                for (int i = 1; i <= 6; i++) cpu_write(3'd0, 16'(i));
                cpu_read_check(3'd2, status_word(1'b1, 1'b1, 1'b0, 4, 1'b1), "status overflow");
                cpu_read_check(3'd2, status_word(1'b1, 1'b1, 1'b0, 4, 1'b0), "status ovf cleared");
            end
            begin
                idle(2);
                for (int i = 1; i <= 5; i++) check_frame(8'(i), 1'b0);
            end
        join
        cpu_read_check(3'd2, 16'h0004, "status after burst");

        // Reset in the middle of data bit 3 of 0x00.
        cpu_write(3'd0, 16'h0000);
        idle(18);
        check_eq("txd before reset", {15'b0, txd}, 16'h0000);
        reset = 1'b1;
        #1;
        check_eq("txd async reset", {15'b0, txd}, 16'h0001);
        check_eq("irq async reset", {15'b0, tx_irq}, 16'h0000);
        idle(2);
        reset = 1'b0;
        cpu_read_check(3'd2, 16'h0004, "status after abort");
        lows = 0;
        repeat (60) begin
            idle(1);
            if (txd !== 1'b1) lows++;
        end
        check_eq("txd quiet after abort", 16'(lows), 16'h0000);

        // Interrupt: high when idle and drained, low throughout the frame.
        cpu_write(3'd4, 16'h0001);
        cpu_read_check(3'd4, 16'h0001, "ctrl irq_en");
        idle(1);
        check_eq("irq idle", {15'b0, tx_irq}, 16'h0001);
        cpu_write(3'd0, 16'h00A3);
        idle(1);
        check_frame(8'hA3, 1'b0);
        check_eq("irq on idle entry", {15'b0, tx_irq}, 16'h0000);
        idle(1);
        check_eq("irq after idle", {15'b0, tx_irq}, 16'h0001);

        // Unmapped and unqualified reads.
        cpu_read_check(3'd6, 16'h0000, "read offset 6");
        ioread  = 1'b1;
        address = 3'd4;
        #1;
        check_eq("read no uartctrl", rdata, 16'h0000);
        ioread   = 1'b0;
        uartctrl = 1'b1;
        address  = 3'd2;
        #1;
        check_eq("select no ioread", rdata, 16'h0000);
        uartctrl = 1'b0;
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
